pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 22 ++
 rtl/pipe_hazard_ctrl_if.sv | 43 ++++
 rtl/stall_watchdog.sv | 35 +++
 rtl/pipe_hazard_ctrl.sv | 92 +++++++++
 tb/tb_pipe_hazard_ctrl.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared definitions for the pipeline hazard controller.
//   pend_state_e      : redirect tracking FSM state (IDLE / PEND)
//   STG_*             : pipeline register indices (PC .. MEM/WB)
//   DEF_*             : default stage count and flush stage positions
package pipe_ctrl_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      PEND = 1'b1
   } pend_state_e;

   localparam int STG_PC     = 0;
   localparam int STG_IFID   = 1;
   localparam int STG_IDEXE  = 2;
   localparam int STG_EXEMEM = 3;
   localparam int STG_MEMWB  = 4;

   localparam int DEF_NSTAGE  = 5;
   localparam int DEF_BR_STG  = STG_IFID;
   localparam int DEF_EXC_STG = STG_EXEMEM;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: request/response bundle between the pipeline and the
// hazard controller.
//   requests  (master -> slave): exc_req, redirect_req, stall_req[NSTAGE],
//                                icache_busy, dcache_busy
//   responses (slave -> master): stage_wr[NSTAGE], stage_flush[NSTAGE],
//                                icache_flush, dcache_flush, wb_diswr,
//                                redirect_pending, stall_cnt[CNT_W],
//                                stall_timeout
interface pipe_hazard_ctrl_if
   import pipe_ctrl_pkg::*;
#(
   parameter int NSTAGE = DEF_NSTAGE,
   parameter int CNT_W  = 8
) ();

   logic              exc_req;
   logic              redirect_req;
   logic [NSTAGE-1:0] stall_req;
   logic              icache_busy;
   logic              dcache_busy;

   logic [NSTAGE-1:0] stage_wr;
   logic [NSTAGE-1:0] stage_flush;
   logic              icache_flush;
   logic              dcache_flush;
   logic              wb_diswr;
   logic              redirect_pending;
   logic [CNT_W-1:0]  stall_cnt;
   logic              stall_timeout;

   modport master (
      output exc_req, redirect_req, stall_req, icache_busy, dcache_busy,
      input  stage_wr, stage_flush, icache_flush, dcache_flush, wb_diswr,
             redirect_pending, stall_cnt, stall_timeout
   );

   modport slave (
      input  exc_req, redirect_req, stall_req, icache_busy, dcache_busy,
      output stage_wr, stage_flush, icache_flush, dcache_flush, wb_diswr,
             redirect_pending, stall_cnt, stall_timeout
   );

endinterface

// File: rtl/stall_watchdog.sv
// stall_watchdog: counts consecutive stall cycles and flags a timeout.
//   clk, resetn   : clock, synchronous active-low reset
//   stall_cyc     : this cycle is a stall cycle (count), else clear
//   stall_cnt     : saturating consecutive-stall counter
//   stall_timeout : sticky once the count reaches TIMEOUT, cleared with count
module stall_watchdog #(
   parameter int CNT_W   = 8,
   parameter int TIMEOUT = 200
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             stall_cyc,
   output logic [CNT_W-1:0] stall_cnt,
   output logic             stall_timeout
);

   logic [CNT_W-1:0] cnt_nxt;

   always_comb begin
      cnt_nxt = '0;
      if (stall_cyc) cnt_nxt = (&stall_cnt) ? stall_cnt : stall_cnt + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         stall_cnt     <= '0;
         stall_timeout <= 1'b0;
      end else begin
         stall_cnt     <= cnt_nxt;
         // sticky within a stall run, dropped on the first clearing cycle
         stall_timeout <= stall_cyc & (stall_timeout | (32'(cnt_nxt) >= TIMEOUT));
      end
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline stall/flush arbiter.
//   clk, resetn : clock, synchronous active-low reset
//   bus         : pipe_hazard_ctrl_if slave (hazard requests in,
//                 per-stage write/flush controls and watchdog status out)
// Priority: exception > cache hold > stall at/after the branch stage >
// redirect > stall before the branch stage > run. A redirect that cannot be
// applied is parked in PEND and retried until it gets through.
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int NSTAGE  = DEF_NSTAGE,
   parameter int BR_STG  = DEF_BR_STG,
   parameter int EXC_STG = DEF_EXC_STG,
   parameter int CNT_W   = 8,
   parameter int TIMEOUT = 200
) (
   input  logic               clk,
   input  logic               resetn,
   pipe_hazard_ctrl_if.slave  bus
);

   pend_state_e       state;
   logic              hold, stall_any, stall_hi, eff_redir;
   int                k;
   logic [NSTAGE-1:0] wr_c, flush_c;
   logic              icf_c, dcf_c, diswr_c;

   // highest stalled stage index
   always_comb begin
      k = 0;
      for (int i = 0; i < NSTAGE; i++)
         if (bus.stall_req[i]) k = i;
   end

   assign hold      = bus.icache_busy | bus.dcache_busy;
   assign stall_any = |bus.stall_req;
   assign stall_hi  = stall_any && (k >= BR_STG);
   assign eff_redir = bus.redirect_req | (state == PEND);

   always_comb begin
      wr_c    = '1;
      flush_c = '0;
      icf_c   = 1'b0;
      dcf_c   = 1'b0;
      diswr_c = 1'b0;
      if (!resetn) begin
         wr_c    = '0;
         diswr_c = 1'b1;
      end else if (bus.exc_req) begin
         for (int i = 1; i <= EXC_STG && i < NSTAGE; i++) flush_c[i] = 1'b1;
         icf_c = 1'b1;
         dcf_c = 1'b1;
      end else if (hold) begin
         wr_c    = '0;
         diswr_c = 1'b1;
      end else if (stall_hi || (stall_any && !eff_redir)) begin
         // freeze 0..k, bubble into k+1 (drops off the end when k is last)
         for (int i = 0; i < NSTAGE; i++) begin
            wr_c[i]    = (i > k);
            flush_c[i] = (i == k + 1);
         end
      end else if (eff_redir) begin
         flush_c[BR_STG] = 1'b1;
         icf_c           = 1'b1;
      end
      flush_c[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!resetn)                state <= IDLE;
      else if (bus.exc_req)       state <= IDLE;
      else if (hold)              begin if (bus.redirect_req) state <= PEND; end
      else if (stall_hi)          begin if (eff_redir) state <= PEND; end
      else if (eff_redir)         state <= IDLE;
   end

   assign bus.stage_wr         = wr_c;
   assign bus.stage_flush      = flush_c;
   assign bus.icache_flush     = icf_c;
   assign bus.dcache_flush     = dcf_c;
   assign bus.wb_diswr         = diswr_c;
   assign bus.redirect_pending = (state == PEND);

   stall_watchdog #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) u_wdog (
      .clk           (clk),
      .resetn        (resetn),
      .stall_cyc     ((hold | stall_any) & ~bus.exc_req),
      .stall_cnt     (bus.stall_cnt),
      .stall_timeout (bus.stall_timeout)
   );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed bench for pipe_hazard_ctrl. Each step drives
// one cycle of requests and queues the expected combinational response plus
// the expected redirect_pending; the queue is drained at the falling edge.
// A second instance with a 4-bit counter shares the stimulus.
module tb_pipe_hazard_ctrl;
   import pipe_ctrl_pkg::*;

   typedef struct packed {
      logic [4:0] wr;
      logic [4:0] flush;
      logic       icf;
      logic       dcf;
      logic       diswr;
      logic       pend;
   } exp_t;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       exc = 1'b0, redir = 1'b0, ib = 1'b0, db = 1'b0;
   logic [4:0] stall = '0;
   exp_t       sb[$];
   int         n_cmp = 0, n_err = 0;

   always #5 clk = ~clk;

   pipe_hazard_ctrl_if #(.NSTAGE(5), .CNT_W(8)) bus ();
   pipe_hazard_ctrl_if #(.NSTAGE(5), .CNT_W(4)) bus4 ();

   assign bus.exc_req       = exc;
   assign bus.redirect_req  = redir;
   assign bus.stall_req     = stall;
   assign bus.icache_busy   = ib;
   assign bus.dcache_busy   = db;
   assign bus4.exc_req      = exc;
   assign bus4.redirect_req = redir;
   assign bus4.stall_req    = stall;
   assign bus4.icache_busy  = ib;
   assign bus4.dcache_busy  = db;

   pipe_hazard_ctrl #(.NSTAGE(5), .BR_STG(1), .EXC_STG(3), .CNT_W(8), .TIMEOUT(200)) dut (
      .clk(clk), .resetn(resetn), .bus(bus.slave));

   pipe_hazard_ctrl #(.NSTAGE(5), .BR_STG(1), .EXC_STG(3), .CNT_W(4), .TIMEOUT(12)) dut4 (
      .clk(clk), .resetn(resetn), .bus(bus4.slave));

   function automatic exp_t mk(logic [4:0] wr, logic [4:0] fl, logic icf, logic dcf,
                               logic dis, logic pend);
      mk = '{wr: wr, flush: fl, icf: icf, dcf: dcf, diswr: dis, pend: pend};
   endfunction

   task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      assert (obs === exp_v) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic check(input string tag);
      exp_t x;
      if (sb.size() == 0) begin
         cmp({tag, ".sb_empty"}, 32'd0, 32'd1);
      end else begin
         x = sb.pop_front();
         cmp({tag, ".stage_wr"},     32'(bus.stage_wr),         32'(x.wr));
         cmp({tag, ".stage_flush"},  32'(bus.stage_flush),      32'(x.flush));
         cmp({tag, ".icache_flush"}, 32'(bus.icache_flush),     32'(x.icf));
         cmp({tag, ".dcache_flush"}, 32'(bus.dcache_flush),     32'(x.dcf));
         cmp({tag, ".wb_diswr"},     32'(bus.wb_diswr),         32'(x.diswr));
         cmp({tag, ".pending"},      32'(bus.redirect_pending), 32'(x.pend));
      end
   endtask

   // drive one cycle of requests just after the rising edge, check at the falling edge
   task automatic step(input string tag, input logic r, input logic e, input logic rd,
                       input logic [4:0] st, input logic i_b, input logic d_b, input exp_t x);
      @(posedge clk);
      #1;
      resetn = r; exc = e; redir = rd; stall = st; ib = i_b; db = d_b;
      sb.push_back(x);
      @(negedge clk);
      check(tag);
   endtask

   initial begin
      repeat (2) @(posedge clk);

      // reset state
      step("rst", 0, 0, 0, 5'h00, 0, 0, mk(5'h00, 5'h00, 0, 0, 1, 0));
      cmp("rst.cnt", 32'(bus.stall_cnt), 0);
      cmp("rst.timeout", 32'(bus.stall_timeout), 0);
      cmp("rst.cnt4", 32'(bus4.stall_cnt), 0);

      // basic run and stall patterns
      step("idle",     1, 0, 0, 5'h00, 0, 0, mk(5'h1F, 5'h00, 0, 0, 0, 0));
      step("stall_k0", 1, 0, 0, 5'h01, 0, 0, mk(5'h1E, 5'h02, 0, 0, 0, 0));
      step("stall_k4", 1, 0, 0, 5'h10, 0, 0, mk(5'h00, 5'h00, 0, 0, 0, 0));
      step("stall_k3", 1, 0, 0, 5'h0A, 0, 0, mk(5'h10, 5'h10, 0, 0, 0, 0));
      step("k0_redir", 1, 0, 1, 5'h01, 0, 0, mk(5'h1F, 5'h02, 1, 0, 0, 0));
      step("idle2",    1, 0, 0, 5'h00, 0, 0, mk(5'h1F, 5'h00, 0, 0, 0, 0));
      cmp("idle2.cnt", 32'(bus.stall_cnt), 4);

      // redirect parked behind an icache hold
      step("hold_rd1", 1, 0, 1, 5'h00, 1, 0, mk(5'h00, 5'h00, 0, 0, 1, 0));
      step("hold_rd2", 1, 0, 1, 5'h00, 1, 0, mk(5'h00, 5'h00, 0, 0, 1, 1));
      step("hold_rd3", 1, 0, 1, 5'h00, 1, 0, mk(5'h00, 5'h00, 0, 0, 1, 1));
      step("rd_apply", 1, 0, 0, 5'h00, 0, 0, mk(5'h1F, 5'h02, 1, 0, 0, 1));
      cmp("rd_apply.cnt", 32'(bus.stall_cnt), 3);
      step("rd_done",  1, 0, 0, 5'h00, 0, 0, mk(5'h1F, 5'h00, 0, 0, 0, 0));
      cmp("rd_done.cnt", 32'(bus.stall_cnt), 0);

      // redirect parked behind a stall at ID/EXE
      step("st_rd1",   1, 0, 1, 5'h04, 0, 0, mk(5'h18, 5'h08, 0, 0, 0, 0));
      step("st_rd2",   1, 0, 0, 5'h04, 0, 0, mk(5'h18, 5'h08, 0, 0, 0, 1));
      step("st_apply", 1, 0, 0, 5'h00, 0, 0, mk(5'h1F, 5'h02, 1, 0, 0, 1));
      step("st_done",  1, 0, 0, 5'h00, 0, 0, mk(5'h1F, 5'h00, 0, 0, 0, 0));

      // exception overrides hold, stalls and a pending redirect
      step("exc_pre",  1, 0, 1, 5'h00, 1, 0, mk(5'h00, 5'h00, 0, 0, 1, 0));
      step("exc",      1, 1, 0, 5'h1F, 0, 1, mk(5'h1F, 5'h0E, 1, 1, 0, 1));
      step("exc_post", 1, 0, 0, 5'h00, 0, 0, mk(5'h1F, 5'h00, 0, 0, 0, 0));
      cmp("exc_post.cnt", 32'(bus.stall_cnt), 0);

      // long dcache hold: timeout and saturation
      for (int i = 1; i <= 205; i++) begin
         step("dhold", 1, 0, 0, 5'h00, 0, 1, mk(5'h00, 5'h00, 0, 0, 1, 0));
         if (i == 12)  cmp("dhold12.timeout4", 32'(bus4.stall_timeout), 0);
         if (i == 13)  cmp("dhold13.timeout4", 32'(bus4.stall_timeout), 1);
         if (i == 15)  cmp("dhold15.cnt4", 32'(bus4.stall_cnt), 14);
         if (i == 21)  cmp("dhold21.cnt4", 32'(bus4.stall_cnt), 15);
         if (i == 200) begin
            cmp("dhold200.cnt", 32'(bus.stall_cnt), 199);
            cmp("dhold200.timeout", 32'(bus.stall_timeout), 0);
         end
         if (i == 201) begin
            cmp("dhold201.cnt", 32'(bus.stall_cnt), 200);
            cmp("dhold201.timeout", 32'(bus.stall_timeout), 1);
         end
      end
      step("dh_idle1", 1, 0, 0, 5'h00, 0, 0, mk(5'h1F, 5'h00, 0, 0, 0, 0));
      cmp("dh_idle1.cnt", 32'(bus.stall_cnt), 205);
      cmp("dh_idle1.timeout", 32'(bus.stall_timeout), 1);
      cmp("dh_idle1.cnt4", 32'(bus4.stall_cnt), 15);
      step("dh_idle2", 1, 0, 0, 5'h00, 0, 0, mk(5'h1F, 5'h00, 0, 0, 0, 0));
      cmp("dh_idle2.cnt", 32'(bus.stall_cnt), 0);
      cmp("dh_idle2.timeout", 32'(bus.stall_timeout), 0);
      cmp("dh_idle2.cnt4", 32'(bus4.stall_cnt), 0);

      // reset while a redirect is pending discards it
      step("rp_pre", 1, 0, 1, 5'h00, 1, 0, mk(5'h00, 5'h00, 0, 0, 1, 0));
      step("rp_rst1", 0, 0, 1, 5'h00, 0, 0, mk(5'h00, 5'h00, 0, 0, 1, 1));
      step("rp_rst2", 0, 0, 0, 5'h00, 0, 0, mk(5'h00, 5'h00, 0, 0, 1, 0));
      step("rp_rel",  1, 0, 0, 5'h00, 0, 0, mk(5'h1F, 5'h00, 0, 0, 0, 0));
      step("rp_idle", 1, 0, 0, 5'h00, 0, 0, mk(5'h1F, 5'h00, 0, 0, 0, 0));

      cmp("sb.left", 32'(sb.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
